// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and op-decode helpers for muldiv_unit.
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMadd  = 3'd4,
    OpMaddu = 3'd5,
    OpMsub  = 3'd6,
    OpMsubu = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StAcc  = 3'd2,
    StDiv  = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return op inside {OpMult, OpDiv, OpMadd, OpMsub};
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op inside {OpMsub, OpMsubu};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] rem_q, quot_q, den_q;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;

  logic [WIDTH:0]   rem_ext;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  assign rem_ext = {rem_q, quot_q[WIDTH-1]};
  assign fits    = rem_ext >= {1'b0, den_q};
  assign trial   = rem_ext[WIDTH-1:0] - den_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      den_q  <= divisor_i;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (annul_i) begin
        run_q <= 1'b0;
      end else begin
        rem_q  <= fits ? trial : rem_ext[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], fits};
        cnt_q  <= cnt_q + CntW'(1);
        if (cnt_q == LastCnt) run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q & ~annul_i & (cnt_q == LastCnt);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV (and MADD/MSUB when MULDIV_MADD_EN is defined) unit beside EX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o,
  output logic             div_zero_o
);

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] res_q;
  logic               divz_q;
`ifdef MULDIV_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
`endif

  logic op_legal, accept, div_start, div_done, write;
  logic [WIDTH-1:0] mag1, mag2, div_quot, div_rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, res_sel;

`ifdef MULDIV_MADD_EN
  assign op_legal = 1'b1;
`else
  logic unused_acc_in;
  assign unused_acc_in = ^{hi_i, lo_i};
  assign op_legal = ~op_is_acc(op_i);
`endif

  assign accept    = (state_q == StIdle) & start_i & ~annul_i & op_legal;
  assign div_start = accept & op_is_div(op_i) & (opdata2_i != '0);

  assign mag1 = (op_is_signed(op_i) & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (op_is_signed(op_i) & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .annul_i   (annul_i),
    .dividend_i(mag1),
    .divisor_i (mag2),
    .quot_o    (div_quot),
    .rem_o     (div_rem),
    .done_o    (div_done)
  );

  assign a_ext   = op_is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = op_is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      divz_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= op_i;
            a_q    <= opdata1_i;
            b_q    <= opdata2_i;
            divz_q <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q  <= {hi_i, lo_i};
`endif
            if (!op_is_div(op_i)) begin
              state_q <= StMul;
            end else if (opdata2_i == '0) begin
              res_q   <= {opdata1_i, {WIDTH{1'b1}}};
              divz_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StMul: begin
          if (annul_i) begin
            state_q <= StIdle;
          end else begin
            res_q <= product;
`ifdef MULDIV_MADD_EN
            state_q <= op_is_acc(op_q) ? StAcc : StDone;
`else
            state_q <= StDone;
`endif
          end
        end
`ifdef MULDIV_MADD_EN
        StAcc: begin
          if (annul_i) begin
            state_q <= StIdle;
          end else begin
            res_q   <= op_is_sub(op_q) ? acc_q - res_q : acc_q + res_q;
            state_q <= StDone;
          end
        end
`endif
        StDiv: begin
          if (annul_i)       state_q <= StIdle;
          else if (div_done) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Signed fixup: quotient sign from operand signs, remainder follows the dividend.
  assign q_fix = (op_is_signed(op_q) & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quot : div_quot;
  assign r_fix = (op_is_signed(op_q) & a_q[WIDTH-1]) ? -div_rem : div_rem;
  assign res_sel = (op_is_div(op_q) & ~divz_q) ? {r_fix, q_fix} : res_q;

  assign write       = (state_q == StDone) & ~annul_i;
  assign whilo_o     = write ? WriteEnable : WriteDisable;
  assign hi_o        = write ? res_sel[2*WIDTH-1:WIDTH] : '0;
  assign lo_o        = write ? res_sel[WIDTH-1:0] : '0;
  assign div_zero_o  = write & divz_q;
  assign busy_o      = (state_q != StIdle);
  assign stall_req_o = (rst & accept) | (state_q == StMul) | (state_q == StAcc) |
                       (state_q == StDiv);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk, rst, start_i, annul_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i, hi_i, lo_i;
  logic        stall_req_o, busy_o, whilo_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .annul_i    (annul_i),
    .stall_req_o(stall_req_o),
    .busy_o     (busy_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: results from plain 64-bit arithmetic, latency from the op class.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b, h, l,
                                output logic [31:0] eh, el, output logic ez,
                                output int lat, output bit legal);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ez = 1'b0;
    legal = 1'b1;
    if (op == OpMult || op == OpMadd || op == OpMsub) p = sa * sb;
    else p = ua * ub;
    case (op)
      OpMult, OpMultu: begin
        {eh, el} = p;
        lat = 2;
      end
      OpMadd, OpMaddu, OpMsub, OpMsubu: begin
        acc = (op == OpMsub || op == OpMsubu) ? {h, l} - p : {h, l} + p;
        {eh, el} = acc;
        lat = 3;
`ifndef MULDIV_MADD_EN
        legal = 1'b0;
`endif
      end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
          ez = 1'b1;
          lat = 1;
        end else begin
          if (op == OpDiv) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          el = q[31:0];
          eh = r[31:0];
          lat = 33;
        end
      end
    endcase
  endfunction

  // Runs one request from accept through write (or annul), checking every cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b, h, l,
                        input int annul_cyc);
    logic [31:0] eh, el;
    logic ez, exp_w;
    int lat, last;
    bit legal;
    model(op, a, b, h, l, eh, el, ez, lat, legal);
    last = !legal ? 1 : (annul_cyc < lat ? annul_cyc : lat);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l;
    annul_i = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (c == annul_cyc) annul_i = 1'b1;
      @(negedge clk);
      exp_w = legal && c == lat && c != annul_cyc;
      chk({tag, " stall"}, {31'd0, stall_req_o}, {31'd0, legal && c < lat});
      chk({tag, " busy"}, {31'd0, busy_o}, {31'd0, legal && c >= 1});
      chk({tag, " whilo"}, {31'd0, whilo_o}, {31'd0, exp_w});
      chk({tag, " hi"}, hi_o, exp_w ? eh : 32'd0);
      chk({tag, " lo"}, lo_o, exp_w ? el : 32'd0);
      chk({tag, " divz"}, {31'd0, div_zero_o}, {31'd0, exp_w & ez});
      @(posedge clk); #1;
      annul_i = 1'b0;
      if (c == 0) begin
        // HI/LO and operands moving after accept must not affect the result.
        hi_i = $urandom; lo_i = $urandom; opdata1_i = $urandom; opdata2_i = $urandom;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, " idle busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " idle whilo"}, {31'd0, whilo_o}, 32'd0);
  endtask

  logic [2:0]  rop;
  logic [31:0] ra, rb;
  int          acyc;

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0;
    opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
    #12;
    chk("reset busy", {31'd0, busy_o}, 32'd0);
    chk("reset whilo", {31'd0, whilo_o}, 32'd0);
    chk("reset stall", {31'd0, stall_req_o}, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    @(negedge clk); rst = 1'b1;

    run_op("mult", OpMult, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'd0, 1000);
    run_op("multu", OpMultu, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'd0, 1000);
    run_op("div neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1000);
    run_op("divu zero", OpDivu, 32'd7, 32'd0, 32'd0, 32'd0, 1000);
    run_op("div zero", OpDiv, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1000);
    run_op("div minneg", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1000);
    run_op("divu big", OpDivu, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd0, 1000);
    run_op("madd", OpMadd, 32'd4, 32'd5, 32'd0, 32'd10, 1000);
    run_op("msubu", OpMsubu, 32'd3, 32'd7, 32'd0, 32'd5, 1000);
    run_op("div annul", OpDiv, 32'd1000, 32'd7, 32'd0, 32'd0, 10);
    run_op("mult annul done", OpMult, 32'd9, 32'd9, 32'd0, 32'd0, 2);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OpDiv; opdata1_i = 32'd100; opdata2_i = 32'd3;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("rst pre stall", {31'd0, stall_req_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst busy", {31'd0, busy_o}, 32'd0);
    chk("rst whilo", {31'd0, whilo_o}, 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("post rst whilo", {31'd0, whilo_o}, 32'd0);
    end
    run_op("mult after rst", OpMult, 32'h0001_0000, 32'hFFFF_0000, 32'd0, 32'd0, 1000);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = $urandom_range(0, 20);
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      acyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 1000;
      run_op("random", rop, ra, rb, $urandom, $urandom, acyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
